// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared definitions for the bus arbiter.
//   - state_t / ST_* : arbiter FSM state encodings
//   - clients_clog2  : width of a client index for a given client count (min 1)
package bus_arb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_GRANT   = 2'd1;
  localparam state_t ST_RELEASE = 2'd2;

  // Index width for n clients; a single bit is kept even for n <= 2.
  function automatic int clients_clog2(input int n);
    int w;
    w = 1;
    for (int i = 1; i <= 8; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// rr_picker: combinational round-robin winner search.
//   req       : request vector, one bit per client
//   ptr       : client with highest priority this round
//   winner    : first requesting client at or above ptr, wrapping to 0
//   any_valid : at least one request bit is set
module rr_picker #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] winner,
  output logic          any_valid
);

  int idx;

  // Walk from the lowest priority position back to ptr so the last hit
  // written is the highest-priority requester.
  always_comb begin
    winner    = '0;
    any_valid = |req;
    idx       = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (req[idx]) winner = PW'(idx);
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter giving N_CLIENTS clients access to one
// memory slave.
//   clk, reset           : clock, asynchronous active-high reset
//   c_rq/c_wr_ni         : per-client request and direction (1 = read)
//   c_addr/c_dataW       : packed per-client address and write data
//   c_ack/c_err          : per-client acknowledge / timeout error (one-hot)
//   c_dataR              : slave read data broadcast to all clients
//   s_rq/s_wr_ni         : request and direction towards the slave
//   s_address/s_dataW    : address and write data towards the slave
//   s_ack/s_dataR        : slave acknowledge and read data
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int N_CLIENTS  = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [N_CLIENTS-1:0]             c_rq,
  input  logic [N_CLIENTS-1:0]             c_wr_ni,
  input  logic [N_CLIENTS*ADDR_WIDTH-1:0]  c_addr,
  input  logic [N_CLIENTS*DATA_WIDTH-1:0]  c_dataW,
  output logic [N_CLIENTS-1:0]             c_ack,
  output logic [N_CLIENTS-1:0]             c_err,
  output logic [DATA_WIDTH-1:0]            c_dataR,
  output logic                             s_rq,
  output logic                             s_wr_ni,
  output logic [ADDR_WIDTH-1:0]            s_address,
  output logic [DATA_WIDTH-1:0]            s_dataW,
  input  logic                             s_ack,
  input  logic [DATA_WIDTH-1:0]            s_dataR
);

  localparam int PW = clients_clog2(N_CLIENTS);

  state_t                state_q, state_d;
  logic [PW-1:0]         grant_q, grant_d;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic [7:0]            wait_q, wait_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  wr_q, wr_d;

  logic [PW-1:0]         winner;
  logic                  any_valid;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_wr;
  logic                  sel_rq;
  logic                  in_grant;
  logic                  ack_hit;
  logic                  timeout_hit;
  logic [PW-1:0]         ptr_after_grant;
  logic [N_CLIENTS-1:0]  grant_onehot;

  rr_picker #(
    .N  (N_CLIENTS),
    .PW (PW)
  ) u_picker (
    .req       (c_rq),
    .ptr       (ptr_q),
    .winner    (winner),
    .any_valid (any_valid)
  );

  assign sel_addr = c_addr[grant_q*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_data = c_dataW[grant_q*DATA_WIDTH +: DATA_WIDTH];
  assign sel_wr   = c_wr_ni[grant_q];
  assign sel_rq   = c_rq[grant_q];
  assign in_grant = (state_q == ST_GRANT);

  // The slave ack only counts while the granted client still requests;
  // an ack in the timeout cycle wins over the error.
  assign ack_hit     = in_grant & sel_rq & s_ack;
  assign timeout_hit = in_grant & sel_rq & ~s_ack & (wait_q == 8'(TIMEOUT - 1));

  assign ptr_after_grant = (grant_q == PW'(N_CLIENTS - 1)) ? '0 : grant_q + 1'b1;
  assign grant_onehot    = {{(N_CLIENTS-1){1'b0}}, 1'b1} << grant_q;

  assign s_rq      = in_grant & sel_rq;
  assign s_wr_ni   = in_grant ? sel_wr   : wr_q;
  assign s_address = in_grant ? sel_addr : addr_q;
  assign s_dataW   = in_grant ? sel_data : data_q;
  assign c_ack     = ack_hit     ? grant_onehot : '0;
  assign c_err     = timeout_hit ? grant_onehot : '0;
  assign c_dataR   = s_dataR;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    wait_d  = wait_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_d    = wr_q;
    case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          grant_d = winner;
          wait_d  = '0;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // Track the granted client so the slave side holds its last values.
        addr_d = sel_addr;
        data_d = sel_data;
        wr_d   = sel_wr;
        wait_d = wait_q + 8'd1;
        if (!sel_rq) begin
          state_d = ST_RELEASE;
        end else if (ack_hit || timeout_hit) begin
          ptr_d   = ptr_after_grant;
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      wait_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      wait_q  <= wait_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: self-checking bench for bus_arbiter with a behavioural
// memory slave of programmable ack delay and a response scoreboard.
module tb_bus_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    c_rq, c_wr_ni, c_ack, c_err;
  logic [N*AW-1:0] c_addr;
  logic [N*DW-1:0] c_dataW;
  logic [DW-1:0]   c_dataR, s_dataW, s_dataR;
  logic            s_rq, s_wr_ni, s_ack;
  logic [AW-1:0]   s_address;

  always #5 clk = ~clk;

  bus_arbiter #(
    .N_CLIENTS  (N),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .TIMEOUT    (TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .c_rq      (c_rq),
    .c_wr_ni   (c_wr_ni),
    .c_addr    (c_addr),
    .c_dataW   (c_dataW),
    .c_ack     (c_ack),
    .c_err     (c_err),
    .c_dataR   (c_dataR),
    .s_rq      (s_rq),
    .s_wr_ni   (s_wr_ni),
    .s_address (s_address),
    .s_dataW   (s_dataW),
    .s_ack     (s_ack),
    .s_dataR   (s_dataR)
  );

  // ---------------- slave model ----------------
  logic [DW-1:0] mem [16];
  int            slv_delay = 0;
  logic          slv_noack = 1'b0;
  int            slv_cnt   = 0;

  assign s_ack   = s_rq && !slv_noack && (slv_cnt == slv_delay);
  assign s_dataR = mem[s_address];

  always @(posedge clk) begin
    if (!s_rq) slv_cnt <= 0;
    else if (!s_ack) slv_cnt <= slv_cnt + 1;
  end

  always @(posedge clk) begin
    if (s_ack && !s_wr_ni) mem[s_address] = s_dataW;
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [N-1:0]  ack;
    logic [N-1:0]  err;
    logic          chk_rd;
    logic [DW-1:0] rd;
    logic          chk_wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   ack_cyc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!reset && ((c_ack | c_err) != '0)) begin
      if (sb.size() == 0) begin
        check("unexpected_response", 32'(c_ack | c_err), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("resp @%0d: c_ack=%b c_err=%b c_dataR=%h", cyc, c_ack, c_err, c_dataR);
        check("c_ack", 32'(c_ack), 32'(e.ack));
        check("c_err", 32'(c_err), 32'(e.err));
        if (e.chk_rd) check("c_dataR", 32'(c_dataR), 32'(e.rd));
        if (e.chk_wr) begin
          check("s_dataW", 32'(s_dataW), 32'(e.wd));
          check("s_address", 32'(s_address), 32'(e.addr));
        end
        if (c_ack != '0) ack_cyc.push_back(cyc);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  typedef struct {
    int            client;
    logic          wr_ni;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    int            delay;
    logic          noack;
    logic [N-1:0]  exp_ack;
    logic [N-1:0]  exp_err;
    logic [DW-1:0] exp_rd;
  } vec_t;

  vec_t vecs[6];

  task automatic wait_resp(input logic [N-1:0] mask, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (((c_ack | c_err) & mask) != '0) begin
        ok = 1'b1;
        break;
      end
    end
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL wait_resp: no response for mask %b within %0d cycles", mask, budget);
    end
  endtask

  task automatic setup_client(input int c, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    c_wr_ni[c]          = wr;
    c_addr[c*AW +: AW]  = a;
    c_dataW[c*DW +: DW] = d;
  endtask

  task automatic push_ack(input int c);
    exp_t e;
    e = '{ack: N'(1) << c, err: '0, chk_rd: 1'b0, rd: '0, chk_wr: 1'b0, addr: '0, wd: '0};
    sb.push_back(e);
  endtask

  task automatic run_one(input vec_t v);
    exp_t e;
    setup_client(v.client, v.wr_ni, v.addr, v.wd);
    slv_delay = v.delay;
    slv_noack = v.noack;
    e = '{ack: v.exp_ack, err: v.exp_err, chk_rd: v.wr_ni && !v.noack, rd: v.exp_rd,
          chk_wr: !v.wr_ni && !v.noack, addr: v.addr, wd: v.wd};
    sb.push_back(e);
    c_rq[v.client] = 1'b1;
    wait_resp(N'(1) << v.client, 60);
    @(posedge clk);
    #1 c_rq[v.client] = 1'b0;
    slv_noack = 1'b0;
  endtask

  // Request several clients at once and expect grants in the given order.
  task automatic run_multi(input logic [N-1:0] mask, input int o0, input int o1, input int o2);
    int ord[3];
    ord = '{o0, o1, o2};
    slv_delay = 0;
    for (int i = 0; i < 3; i++) if (ord[i] >= 0) push_ack(ord[i]);
    c_rq = mask;
    for (int i = 0; i < 3; i++) begin
      if (ord[i] >= 0) begin
        wait_resp(N'(1) << ord[i], 20);
        @(posedge clk);
        #1 c_rq[ord[i]] = 1'b0;
      end
    end
    c_rq = '0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int g;
    for (int i = 0; i < 16; i++) mem[i] = 8'h30 + 8'(i);

    vecs[0] = '{2, 1'b1, 4'h5, 8'h00, 2, 1'b0, 4'b0100, 4'b0000, 8'h35};
    vecs[1] = '{3, 1'b0, 4'h2, 8'hA5, 0, 1'b0, 4'b1000, 4'b0000, 8'h00};
    vecs[2] = '{0, 1'b1, 4'h2, 8'h00, 1, 1'b0, 4'b0001, 4'b0000, 8'hA5};
    vecs[3] = '{1, 1'b0, 4'h7, 8'h5A, 3, 1'b0, 4'b0010, 4'b0000, 8'h00};
    vecs[4] = '{1, 1'b1, 4'h7, 8'h00, 0, 1'b0, 4'b0010, 4'b0000, 8'h5A};
    vecs[5] = '{1, 1'b1, 4'h3, 8'h00, 0, 1'b1, 4'b0000, 4'b0010, 8'h00};

    // Reset with every client requesting: slave side must stay quiet.
    reset   = 1'b1;
    c_rq    = '1;
    c_wr_ni = '1;
    c_addr  = '0;
    c_dataW = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_s_rq", 32'(s_rq), 32'd0);
    check("reset_c_ack", 32'(c_ack), 32'd0);
    check("reset_c_err", 32'(c_err), 32'd0);
    check("reset_s_address", 32'(s_address), 32'd0);
    check("reset_s_dataW", 32'(s_dataW), 32'd0);
    check("reset_s_wr_ni", 32'(s_wr_ni), 32'd0);

    // All four request out of reset with a zero-delay slave.
    ack_cyc.delete();
    slv_delay = 0;
    push_ack(0); push_ack(1); push_ack(2); push_ack(3); push_ack(0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) wait_resp('1, 20);
    @(posedge clk);
    #1 c_rq = '0;
    check("rr_ack_count", 32'(ack_cyc.size()), 32'd5);
    for (int i = 0; i + 1 < ack_cyc.size(); i++)
      check("rr_ack_spacing", 32'(ack_cyc[i+1] - ack_cyc[i]), 32'd3);
    repeat (2) @(posedge clk);
    #1;

    // Reset during the second GRANT cycle (ptr is 1 at this point).
    slv_noack = 1'b1;
    c_rq[1]   = 1'b1;
    g = 0;
    while (!s_rq && g < 20) begin
      @(negedge clk);
      g++;
    end
    check("pre_reset_s_rq", 32'(s_rq), 32'd1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midgrant_reset_s_rq", 32'(s_rq), 32'd0);
    check("midgrant_reset_c_ack", 32'(c_ack), 32'd0);
    check("midgrant_reset_c_err", 32'(c_err), 32'd0);
    c_rq      = '0;
    slv_noack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    setup_client(0, 1'b1, 4'h0, 8'h00);
    setup_client(3, 1'b1, 4'h0, 8'h00);
    run_multi(4'b1001, 0, 3, -1);

    // Table of single-client transactions.
    for (int i = 0; i < 6; i++) begin
      $display("vector %0d: client %0d wr_ni=%b addr=%h wd=%h delay=%0d noack=%b",
               i, vecs[i].client, vecs[i].wr_ni, vecs[i].addr, vecs[i].wd,
               vecs[i].delay, vecs[i].noack);
      run_one(vecs[i]);
    end
    repeat (2) @(posedge clk);
    #1;

    // Timeout timing: GRANT cycles counted up to and including c_err.
    slv_noack = 1'b1;
    begin
      exp_t e;
      e = '{ack: '0, err: 4'b0010, chk_rd: 1'b0, rd: '0, chk_wr: 1'b0, addr: '0, wd: '0};
      sb.push_back(e);
    end
    c_rq[1] = 1'b1;
    g = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (s_rq) g++;
      if (c_err != '0) break;
    end
    check("timeout_grant_cycles", 32'(g), 32'd16);
    @(negedge clk);
    check("timeout_s_rq_next", 32'(s_rq), 32'd0);
    c_rq[1]   = 1'b0;
    slv_noack = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // ptr = 3 after client 2 served: client 3 beats client 0.
    run_one(vecs[0]);
    repeat (2) @(posedge clk);
    #1;
    setup_client(0, 1'b1, 4'h0, 8'h00);
    setup_client(3, 1'b1, 4'h0, 8'h00);
    run_multi(4'b1001, 3, 0, -1);

    // Abort: client 2 served (ptr -> 3), then client 0 drops mid-GRANT.
    run_one(vecs[0]);
    repeat (2) @(posedge clk);
    #1;
    slv_delay = 100;
    c_rq[0]   = 1'b1;
    g = 0;
    while (!s_rq && g < 20) begin
      @(negedge clk);
      g++;
    end
    check("abort_pre_s_rq", 32'(s_rq), 32'd1);
    repeat (2) @(negedge clk);
    c_rq[0] = 1'b0;
    #1;
    check("abort_s_rq", 32'(s_rq), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    setup_client(1, 1'b1, 4'h0, 8'h00);
    run_multi(4'b1011, 3, 0, 1);

    repeat (3) @(posedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
